// File: rtl/pixel_fetch.sv
// Fetches a 3-row by num_cols column block of 32-bit words from memory and
// streams each word, column-major (row 0..2 per column), to shift_data_path.
module pixel_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] row_stride,
  input  logic [15:0] num_cols,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        write_en,
  output logic [31:0] data_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    PUSH,
    DONE
  } state_t;

  state_t      state;
  logic [1:0]  row;
  logic [15:0] col;
  logic [15:0] stride_q;
  logic [15:0] cols_q;
  logic [31:0] col_addr;

  logic last_word;
  assign last_word = (row == 2'd2) && (col == cols_q - 16'd1);

  // col_addr tracks base + col*4; each row below it adds one stride to
  // mem_addr, so no multiplier is needed and 32-bit wrap happens naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      row      <= 2'd0;
      col      <= 16'd0;
      stride_q <= 16'd0;
      cols_q   <= 16'd0;
      col_addr <= 32'd0;
      mem_req  <= 1'b0;
      mem_addr <= 32'd0;
      write_en <= 1'b0;
      data_out <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            stride_q <= row_stride;
            cols_q   <= num_cols;
            row      <= 2'd0;
            col      <= 16'd0;
            col_addr <= base_addr;
            mem_addr <= base_addr;
            busy     <= 1'b1;
            if (num_cols == 16'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= REQ;
              mem_req <= 1'b1;
            end
          end
        end

        REQ: begin
          if (mem_ack) begin
            data_out <= mem_rdata;
            mem_req  <= 1'b0;
            write_en <= 1'b1;
            state    <= PUSH;
          end
        end

        PUSH: begin
          write_en <= 1'b0;
          if (last_word) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state   <= REQ;
            mem_req <= 1'b1;
            if (row == 2'd2) begin
              row      <= 2'd0;
              col      <= col + 16'd1;
              col_addr <= col_addr + 32'd4;
              mem_addr <= col_addr + 32'd4;
            end else begin
              row      <= row + 2'd1;
              mem_addr <= mem_addr + {16'd0, stride_q};
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_fetch.sv
// Directed, table-driven bench for pixel_fetch with a small address/data
// model and hand-written reset and restart sequences.
module tb_pixel_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] row_stride;
  logic [15:0] num_cols;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        write_en;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  int          n_reqs;
  int          n_pushes;
  int          done_cyc;
  logic [31:0] acc [4];

  typedef struct {
    logic [31:0] base;
    logic [15:0] stride;
    logic [15:0] cols;
    int          dly;
    int          restart_mid;
    int          restart_done;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] a3;
    int          exp_reqs;
    int          exp_done;
  } vec_t;

  vec_t vecs [6];

  pixel_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .row_stride(row_stride),
    .num_cols  (num_cols),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .write_en  (write_en),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Called at posedge+1; that cycle is the start cycle (cycle 0).
  task automatic applyStimulus(input vec_t v);
    int row, col, wait_cnt, cyc;
    logic [31:0] exp_data, exp_a;
    bit finished;
    row = 0; col = 0; wait_cnt = 0; cyc = 0;
    n_reqs = 0; n_pushes = 0; done_cyc = -1; finished = 0;
    exp_data = 32'd0;
    base_addr  = v.base;
    row_stride = v.stride;
    num_cols   = v.cols;
    start      = 1'b1;
    mem_ack    = (v.dly == 0);
    mem_rdata  = 32'd0;
    while (!finished && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      start      = (cyc == v.restart_mid);
      base_addr  = 32'hDEAD_BEEF;
      row_stride = 16'h4444;
      num_cols   = 16'd7;
      exp_a = v.base + 32'(row) * {16'd0, v.stride} + 32'(col) * 32'd4;
      if (done) begin
        done_cyc = cyc;
        checkBit("busy_in_done", busy, 1'b1);
        checkBit("req_in_done", mem_req, 1'b0);
        if (v.restart_done != 0) start = 1'b1;
        finished = 1;
      end else begin
        checkBit("busy_running", busy, 1'b1);
      end
      if (mem_req) begin
        checkOutput("req_addr", mem_addr, exp_a);
        checkBit("no_overlap", write_en, 1'b0);
        if (wait_cnt == v.dly) begin
          mem_ack   = 1'b1;
          mem_rdata = $urandom;
          exp_data  = mem_rdata;
          if (n_reqs < 4) acc[n_reqs] = mem_addr;
          n_reqs++;
          wait_cnt = 0;
          if (row == 2) begin
            row = 0;
            col++;
          end else begin
            row++;
          end
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack   = (v.dly == 0);
        mem_rdata = $urandom;
      end
      if (write_en) begin
        n_pushes++;
        checkOutput("push_data", data_out, exp_data);
      end
    end
    if (!finished) checkBit("timeout_waiting_done", 1'b0, 1'b1);
    checkOutput("req_count", 32'(n_reqs), 32'(v.exp_reqs));
    checkOutput("push_count", 32'(n_pushes), 32'(v.exp_reqs));
    checkOutput("done_cycle", 32'(done_cyc), 32'(v.exp_done));
    if (v.exp_reqs > 0) checkOutput("addr0", acc[0], v.a0);
    if (v.exp_reqs > 1) checkOutput("addr1", acc[1], v.a1);
    if (v.exp_reqs > 2) checkOutput("addr2", acc[2], v.a2);
    if (v.exp_reqs > 3) checkOutput("addr3", acc[3], v.a3);
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      checkBit("idle_busy", busy, 1'b0);
      checkBit("idle_done", done, 1'b0);
      checkBit("idle_req", mem_req, 1'b0);
      checkBit("idle_wen", write_en, 1'b0);
    end
  endtask

  initial begin
    vec_t rv;
    // base, stride, cols, dly, restart_mid, restart_done, a0..a3, reqs, done cycle
    vecs[0] = '{32'h0000_1000, 16'h0100, 16'd2, 0, 0, 0,
                32'h0000_1000, 32'h0000_1100, 32'h0000_1200, 32'h0000_1004, 6, 13};
    vecs[1] = '{32'h0000_1000, 16'h0100, 16'd2, 3, 0, 0,
                32'h0000_1000, 32'h0000_1100, 32'h0000_1200, 32'h0000_1004, 6, 31};
    vecs[2] = '{32'h0000_5000, 16'h0010, 16'd0, 0, 0, 0,
                32'h0, 32'h0, 32'h0, 32'h0, 0, 1};
    vecs[3] = '{32'hFFFF_FFFC, 16'h0008, 16'd1, 0, 0, 0,
                32'hFFFF_FFFC, 32'h0000_0004, 32'h0000_000C, 32'h0, 3, 7};
    vecs[4] = '{32'h0000_2000, 16'h0040, 16'd2, 1, 5, 1,
                32'h0000_2000, 32'h0000_2040, 32'h0000_2080, 32'h0000_2004, 6, 19};
    vecs[5] = '{32'h8000_0010, 16'hFFFC, 16'd3, 2, 0, 0,
                32'h8000_0010, 32'h8001_000C, 32'h8002_0008, 32'h8000_0014, 9, 37};

    reset = 1'b1; start = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    base_addr = 32'h1234_5678; row_stride = 16'h10; num_cols = 16'd1;
    repeat (2) @(posedge clk);
    #1;
    checkBit("rst_req", mem_req, 1'b0);
    checkBit("rst_wen", write_en, 1'b0);
    checkBit("rst_busy", busy, 1'b0);
    checkBit("rst_done", done, 1'b0);
    checkOutput("rst_addr", mem_addr, 32'h0);
    checkOutput("rst_data", data_out, 32'h0);
    reset = 1'b0; start = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i]);
    end

    $display("[TB] reset during row-1 wait");
    base_addr = 32'h0000_3000; row_stride = 16'h0010; num_cols = 16'd1;
    start = 1'b1; mem_ack = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    checkOutput("ra_addr0", mem_addr, 32'h0000_3000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(posedge clk); #1; mem_ack = 1'b0;
    checkBit("ra_push", write_en, 1'b1);
    checkOutput("ra_data", data_out, 32'h1234_5678);
    @(posedge clk); #1;
    checkBit("ra_req1", mem_req, 1'b1);
    checkOutput("ra_addr1", mem_addr, 32'h0000_3010);
    @(posedge clk); #1;
    reset = 1'b1; mem_ack = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    checkBit("ra_req", mem_req, 1'b0);
    checkBit("ra_wen", write_en, 1'b0);
    checkBit("ra_busy", busy, 1'b0);
    checkBit("ra_done", done, 1'b0);
    checkOutput("ra_maddr", mem_addr, 32'h0);
    checkOutput("ra_dout", data_out, 32'h0);
    reset = 1'b0; mem_ack = 1'b0; start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkBit("ra_no_done", done, 1'b0);
      checkBit("ra_idle", busy, 1'b0);
    end
    rv = '{32'h0000_3000, 16'h0010, 16'd1, 3, 0, 0,
           32'h0000_3000, 32'h0000_3010, 32'h0000_3020, 32'h0, 3, 16};
    applyStimulus(rv);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
